// File: rtl/cs_to_binary_converter.sv
// -----------------------------------------------------------------------------
// cs_to_binary_converter
//
// Resolves a redundant (carry-save) operand pair into a binary result with a
// chunk-serial ripple adder. One CHUNK-bit slice is added per clock, so a
// WIDTH-bit conversion takes NCHUNK = WIDTH/CHUNK ADD cycles.
//
// Parameters
//   WIDTH    operand/result width in bits (must be a multiple of CHUNK)
//   CHUNK    bits resolved per clock cycle
//
// Ports
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low reset
//   valid_i    operand pair on sum_i/carry_i is valid
//   ready_o    block can accept an operand pair (high only in IDLE)
//   sum_i      sum vector
//   carry_i    carry vector, already weight-aligned to sum_i
//   valid_o    result_o/cout_o valid (high only in DONE)
//   ready_i    downstream accepts the result
//   result_o   (sum_i + carry_i) mod 2^WIDTH, zero outside DONE
//   cout_o     bit WIDTH of sum_i + carry_i, zero outside DONE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps its data stable while valid is high and ready
// is low; valid never depends on ready on the same side.
//
// Optional feature macro: CS_CONV_ZERO_BYPASS_EN
//   When defined, a pair with carry_i == 0 skips the ADD sequence and its
//   result (sum_i, cout 0) is presented in the cycle after acceptance.
// -----------------------------------------------------------------------------
module cs_to_binary_converter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] sum_i,
   input  logic [WIDTH-1:0] carry_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] carry_q, carry_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cy_q, cy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CHUNK:0]   chunk_add;

   // The captured operands are consumed from the bottom: each ADD cycle adds
   // their low chunk and shifts them down by CHUNK. The result register is
   // filled from the top, so after NCHUNK cycles chunk k sits at bits
   // k*CHUNK +: CHUNK without any variable indexing.
   assign chunk_add = {1'b0, sum_q[CHUNK-1:0]}
                    + {1'b0, carry_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, cy_q};

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      res_d   = res_q;
      cy_d    = cy_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (valid_i) begin
               sum_d   = sum_i;
               carry_d = carry_i;
               res_d   = '0;
               cy_d    = 1'b0;
               cnt_d   = '0;
               state_d = ADD;
`ifdef CS_CONV_ZERO_BYPASS_EN
               // Nothing to propagate: the sum vector already is the result.
               if (carry_i == '0) begin
                  res_d   = sum_i;
                  cy_d    = 1'b0;
                  state_d = DONE;
               end
`endif
            end
         end

         ADD: begin
            sum_d   = sum_q >> CHUNK;
            carry_d = carry_q >> CHUNK;
            res_d   = (res_q >> CHUNK)
                    | (WIDTH'(chunk_add[CHUNK-1:0]) << (WIDTH - CHUNK));
            cy_d    = chunk_add[CHUNK];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CHUNK) begin
               state_d = DONE;
            end
         end

         DONE: begin
            // Result and carry registers are not touched here, so the
            // outputs stay stable until the downstream handshake.
            if (ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sum_q   <= '0;
         carry_q <= '0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready_o  = (state_q == IDLE);
   assign valid_o  = (state_q == DONE);
   // Partial results built up during ADD must not leak onto the outputs.
   assign result_o = valid_o ? res_q : '0;
   assign cout_o   = valid_o & cy_q;

endmodule

// File: doc/cs_to_binary_converter.md
CS_TO_BINARY_CONVERTER -- requirements
Module: cs_to_binary_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits resolved per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic is rising-edge triggered.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  upstream redundant operand pair valid.
REQ-006 SHALL have port ready_o  output  1  block can accept an operand pair.
REQ-007 SHALL have port sum_i  input  WIDTH  sum vector from the compressor tree.
REQ-008 SHALL have port carry_i  input  WIDTH  carry vector, already weight-aligned to sum_i by the producer.
REQ-009 SHALL have port valid_o  output  1  result_o/cout_o valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port result_o  output  WIDTH  (sum_i + carry_i) mod 2^WIDTH.
REQ-012 SHALL have port cout_o  output  1  bit WIDTH of sum_i + carry_i.

Function
REQ-013 SHALL implement FSM states IDLE, ADD, DONE.
REQ-014 In IDLE, ready_o SHALL be 1; ready_o SHALL be 0 in ADD and DONE.
REQ-015 On an edge with valid_i=1 in IDLE: capture sum_i and carry_i, clear chunk counter and carry register, go to ADD.
REQ-016 In ADD, each edge SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) of both captured operands plus the carry register, store the CHUNK-bit sum into result chunk k, store carry-out into the carry register, and increment k.
REQ-017 After the edge processing chunk NCHUNK-1, go to DONE; cout_o SHALL equal the final carry-out.
REQ-018 Latency SHALL be NCHUNK+1 edges from the acceptance edge until valid_o=1 (valid_o high in the cycle after the last ADD edge).
REQ-019 In DONE, valid_o SHALL be 1, and result_o/cout_o SHALL hold stable until an edge with ready_i=1, after which the FSM returns to IDLE and valid_o drops.
REQ-020 valid_o SHALL be 0 in IDLE and ADD; result_o and cout_o SHALL be 0 outside DONE.
REQ-021 sum_i/carry_i changes after acceptance SHALL NOT affect the in-flight result.
REQ-022 Back-to-back: a new pair SHALL be accepted no earlier than the edge following the DONE->IDLE edge (one idle cycle minimum).
REQ-023 All-ones plus one SHALL propagate the carry across every chunk boundary, giving result 0 and cout 1.

Reset
REQ-024 rst_ni=0 at an edge SHALL force IDLE, clear counter, carry register, captured operands and result; outputs: ready_o=1, valid_o=0, result_o=0, cout_o=0.
REQ-025 Reset asserted in ADD or DONE SHALL abort the operation; no valid_o pulse SHALL follow.

Configuration
REQ-026 Macro CS_CONV_ZERO_BYPASS_EN SHALL gate a zero-carry bypass.
REQ-027 With CS_CONV_ZERO_BYPASS_EN defined, acceptance with carry_i==0 SHALL load result=sum_i, cout=0 and go directly to DONE (valid_o one edge after acceptance).
REQ-028 Without CS_CONV_ZERO_BYPASS_EN, every operand pair SHALL take the full ADD sequence of REQ-018.

Verification (WIDTH=32, CHUNK=8)
REQ-029 sum_i=0xFFFFFFFF, carry_i=0x00000001, ready_i=1 -> valid_o high 5 cycles after acceptance, result_o=0x00000000, cout_o=1.
REQ-030 sum_i=0x12345678, carry_i=0x11111111, ready_i=0 for 10 cycles -> valid_o and result_o=0x23456789, cout_o=0 held stable until ready_i=1, then IDLE.
REQ-031 Accept pair, pull rst_ni low during ADD chunk 2 -> next cycle ready_o=1, valid_o=0, result_o=0; no valid_o pulse afterwards.
REQ-032 sum_i=0xA0000000, carry_i=0x0000_0005 with macro defined vs undefined -> result_o=0xA0000005, cout_o=0 in both; with carry_i=0 and macro defined, valid_o one cycle after acceptance.
REQ-033 Two pairs offered continuously (0x80000000+0x80000000, then 0x00000001+0x00000002) -> second accepted only after first handshake; results 0x00000000/cout 1, then 0x00000003/cout 0.
REQ-034 Randomized 1000 pairs with random ready_i -> every result_o/cout_o equals the 33-bit reference sum.
